// File: rtl/n_to_kn_demux_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Package : demux_pkg
// Purpose : Shared width helpers and the fill-state encoding for the
//           N-to-KN demux buffer and its slot decoder.
// Contents: state_t    - EMPTY / FILLING / FULL
//           calc_in_w  - bits per input beat
//           calc_out_w - bits per assembled output vector
//           calc_sel_w - slot-index width, never narrower than 1 bit
// Revision: 1.0 - initial release
// ============================================================================
package demux_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  function automatic int calc_in_w(input int units, input int elem_w);
    return elem_w * (units / 2);
  endfunction

  function automatic int calc_out_w(input int units, input int elem_w, input int slots);
    return slots * calc_in_w(units, elem_w);
  endfunction

  // $clog2(2) is already 1; the guard covers a degenerate single-slot build.
  function automatic int calc_sel_w(input int slots);
    return (slots <= 2) ? 1 : $clog2(slots);
  endfunction

endpackage
`default_nettype wire

// File: rtl/n_to_kn_demux_buffer_decoder.sv
`default_nettype none
// ============================================================================
// Module  : slot_onehot_decoder
// Purpose : Turns a slot index plus enable into a one-hot write strobe.
//           An index at or above no_of_slots produces no strobe and raises
//           out_of_range instead (only while enabled).
// Ports   : idx          in  sel_w        slot index
//           en           in  1            write enable
//           strobe       out no_of_slots  one-hot write strobe
//           out_of_range out 1            enabled index >= no_of_slots
// Revision: 1.0 - initial release
// ============================================================================
module slot_onehot_decoder #(
  parameter int no_of_slots = 2,
  parameter int sel_w       = 1
) (
  input  logic [sel_w-1:0]       idx,
  input  logic                   en,
  output logic [no_of_slots-1:0] strobe,
  output logic                   out_of_range
);

  always_comb begin
    strobe       = '0;
    out_of_range = en && (int'(idx) >= no_of_slots);
    for (int s = 0; s < no_of_slots; s++) begin
      strobe[s] = en && (int'(idx) == s);
    end
  end

endmodule
`default_nettype wire

// File: rtl/n_to_kn_demux_buffer.sv
`default_nettype none
// ============================================================================
// Module  : n_to_kn_demux_buffer
// Purpose : Collects no_of_slots half-width input beats into one packed
//           output vector (sequential fill or explicit slot select) and
//           hands it downstream with valid/ready. A flush emits a partial
//           vector; out_mask tells which slots were written.
// Ports   : clk, rst_n (async, active-low)
//           mode                  0 = sequential, 1 = explicit (latched in EMPTY)
//           in_data/in_sel/in_valid/in_ready   input beat handshake
//           flush                 emit a partially filled vector
//           out_data/out_mask/out_valid/out_ready  output vector handshake
//           sel_err               pulse after an out-of-range explicit beat
// Revision: 1.0 - initial release
// ============================================================================
module n_to_kn_demux_buffer
  import demux_pkg::*;
#(
  parameter int no_of_units   = 8,
  parameter int element_width = 32,
  parameter int no_of_slots   = 2,
  localparam int IN_W  = calc_in_w(no_of_units, element_width),
  localparam int OUT_W = calc_out_w(no_of_units, element_width, no_of_slots),
  localparam int SEL_W = calc_sel_w(no_of_slots)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode,
  input  logic [IN_W-1:0]        in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [OUT_W-1:0]       out_data,
  output logic [no_of_slots-1:0] out_mask,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   sel_err
);

  state_t                   state;
  state_t                   next_state;
  logic [SEL_W-1:0]         wr_ptr;
  logic                     mode_q;

  logic                     accept;
  logic                     drain;
  logic                     flush_eff;
  logic [SEL_W-1:0]         base_ptr;
  logic [no_of_slots-1:0]   base_mask;
  logic [OUT_W-1:0]         base_data;
  logic [SEL_W-1:0]         dec_idx;
  logic [no_of_slots-1:0]   strobe;
  logic                     oor;
  logic [no_of_slots-1:0]   new_mask;
  logic [OUT_W-1:0]         new_data;

  assign out_valid = (state == ST_FULL);
  // Combinational from out_ready so a drain and an accept share one cycle.
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;
  assign flush_eff = flush && (state == ST_FILLING);

  // A drain clears the vector first, so a beat accepted in the same cycle
  // lands in the fresh vector rather than the one leaving.
  assign base_ptr  = drain ? '0 : wr_ptr;
  assign base_mask = drain ? '0 : out_mask;
  assign base_data = drain ? '0 : out_data;
  assign dec_idx   = mode_q ? in_sel : base_ptr;

  slot_onehot_decoder #(
    .no_of_slots (no_of_slots),
    .sel_w       (SEL_W)
  ) u_decoder (
    .idx          (dec_idx),
    .en           (accept),
    .strobe       (strobe),
    .out_of_range (oor)
  );

  always_comb begin
    new_mask = base_mask | strobe;
    new_data = base_data;
    for (int s = 0; s < no_of_slots; s++) begin
      if (strobe[s]) new_data[s*IN_W +: IN_W] = in_data;
    end

    next_state = state;
    if (state == ST_FULL && !drain) begin
      next_state = ST_FULL;
    end else if (flush_eff || (&new_mask)) begin
      // Sequential fill reaches all-ones exactly when slot K-1 is written.
      next_state = ST_FULL;
    end else if (|new_mask) begin
      next_state = ST_FILLING;
    end else begin
      next_state = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      wr_ptr   <= '0;
      mode_q   <= 1'b0;
      out_data <= '0;
      out_mask <= '0;
      sel_err  <= 1'b0;
    end else begin
      // While FULL and stalled, accept is low and new_* equal the current
      // contents, so these updates hold the output stable.
      state    <= next_state;
      out_data <= new_data;
      out_mask <= new_mask;
      wr_ptr   <= (accept && !mode_q) ? base_ptr + SEL_W'(1) : base_ptr;
      sel_err  <= accept && mode_q && oor;
      if (state == ST_EMPTY && !accept) mode_q <= mode;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_n_to_kn_demux_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_n_to_kn_demux_buffer
// Purpose : Self-checking bench. Three instances (K = 2, 3, 4) share all
//           inputs; each scenario starts from reset and checks one instance.
//           K=2 runs from a directed vector table, K=3/K=4 and the
//           asynchronous-reset case use short hand-written sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_n_to_kn_demux_buffer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mode;
  logic [127:0] in_data;
  logic [1:0]   in_sel;
  logic         in_valid;
  logic         flush;
  logic         out_ready;

  logic         in_ready2, out_valid2, sel_err2;
  logic [1:0]   out_mask2;
  logic [255:0] out_data2;
  logic         in_ready3, out_valid3, sel_err3;
  logic [2:0]   out_mask3;
  logic [383:0] out_data3;
  logic         in_ready4, out_valid4, sel_err4;
  logic [3:0]   out_mask4;
  logic [511:0] out_data4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  n_to_kn_demux_buffer #(.no_of_units(8), .element_width(32), .no_of_slots(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_data(in_data), .in_sel(in_sel[0:0]),
    .in_valid(in_valid), .in_ready(in_ready2), .flush(flush), .out_data(out_data2),
    .out_mask(out_mask2), .out_valid(out_valid2), .out_ready(out_ready), .sel_err(sel_err2));

  n_to_kn_demux_buffer #(.no_of_units(8), .element_width(32), .no_of_slots(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready3), .flush(flush), .out_data(out_data3),
    .out_mask(out_mask3), .out_valid(out_valid3), .out_ready(out_ready), .sel_err(sel_err3));

  n_to_kn_demux_buffer #(.no_of_units(8), .element_width(32), .no_of_slots(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready4), .flush(flush), .out_data(out_data4),
    .out_mask(out_mask4), .out_valid(out_valid4), .out_ready(out_ready), .sel_err(sel_err4));

  typedef struct {
    logic         mode;
    logic         valid;
    logic [1:0]   sel;
    logic         flush;
    logic         ordy;
    logic [127:0] data;
    logic         exp_valid;
    logic         exp_ready;
    logic         exp_err;
    logic [1:0]   exp_mask;
    logic [255:0] exp_data;
  } vec_t;

  localparam int NVEC = 22;
  vec_t tbl [NVEC];

  logic [127:0] A, B, C, D, E, F, Z;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    mode      = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    A = {32{4'hA}}; B = {32{4'hB}}; C = {32{4'hC}};
    D = {32{4'hD}}; E = {32{4'hE}}; F = {32{4'hF}}; Z = '0;

    //           mode valid sel   flush ordy data | valid ready err mask   data
    tbl[0]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, Z, 1'b0, 1'b1, 1'b0, 2'b00, {Z, Z}};
    tbl[1]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b1, A, 1'b0, 1'b1, 1'b0, 2'b01, {Z, A}};
    tbl[2]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b1, B, 1'b1, 1'b1, 1'b0, 2'b11, {B, A}};
    tbl[3]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b1, C, 1'b0, 1'b1, 1'b0, 2'b01, {Z, C}};
    tbl[4]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b1, D, 1'b1, 1'b1, 1'b0, 2'b11, {D, C}};
    tbl[5]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, Z, 1'b1, 1'b0, 1'b0, 2'b11, {D, C}};
    tbl[6]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, E, 1'b1, 1'b0, 1'b0, 2'b11, {D, C}};
    tbl[7]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, E, 1'b1, 1'b0, 1'b0, 2'b11, {D, C}};
    tbl[8]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, E, 1'b1, 1'b0, 1'b0, 2'b11, {D, C}};
    tbl[9]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, E, 1'b1, 1'b0, 1'b0, 2'b11, {D, C}};
    tbl[10] = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b1, E, 1'b0, 1'b1, 1'b0, 2'b01, {Z, E}};
    tbl[11] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, Z, 1'b0, 1'b1, 1'b0, 2'b01, {Z, E}};
    tbl[12] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b1, Z, 1'b0, 1'b1, 1'b0, 2'b01, {Z, E}};
    tbl[13] = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b1, F, 1'b1, 1'b1, 1'b0, 2'b11, {F, E}};
    tbl[14] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b1, Z, 1'b0, 1'b1, 1'b0, 2'b00, {Z, Z}};
    tbl[15] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b1, Z, 1'b0, 1'b1, 1'b0, 2'b00, {Z, Z}};
    tbl[16] = '{1'b1, 1'b1, 2'd1, 1'b0, 1'b1, A, 1'b0, 1'b1, 1'b0, 2'b10, {A, Z}};
    tbl[17] = '{1'b1, 1'b1, 2'd1, 1'b0, 1'b1, B, 1'b0, 1'b1, 1'b0, 2'b10, {B, Z}};
    tbl[18] = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b1, C, 1'b1, 1'b1, 1'b0, 2'b11, {B, C}};
    tbl[19] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b1, Z, 1'b0, 1'b1, 1'b0, 2'b00, {Z, Z}};
    tbl[20] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, Z, 1'b0, 1'b1, 1'b0, 2'b00, {Z, Z}};
    tbl[21] = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b1, A, 1'b0, 1'b1, 1'b0, 2'b01, {Z, A}};

    // ---------------- reset state (K=2) ----------------
    rst_n = 1'b0; mode = 1'b0; in_data = '0; in_sel = '0;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready",  in_ready2,  1'b1);
    chk("rst_out_valid", out_valid2, 1'b0);
    chk("rst_out_mask",  out_mask2,  2'b00);
    chk("rst_out_data",  out_data2,  256'h0);
    chk("rst_sel_err",   sel_err2,   1'b0);

    // ---------------- K=2 vector table ----------------
    do_reset();
    for (int i = 0; i < NVEC; i++) begin
      mode      = tbl[i].mode;
      in_valid  = tbl[i].valid;
      in_sel    = tbl[i].sel;
      flush     = tbl[i].flush;
      out_ready = tbl[i].ordy;
      in_data   = tbl[i].data;
      step();
      chk($sformatf("vec%0d_out_valid", i), out_valid2, tbl[i].exp_valid);
      chk($sformatf("vec%0d_in_ready", i),  in_ready2,  tbl[i].exp_ready);
      chk($sformatf("vec%0d_sel_err", i),   sel_err2,   tbl[i].exp_err);
      chk($sformatf("vec%0d_out_mask", i),  out_mask2,  tbl[i].exp_mask);
      chk($sformatf("vec%0d_out_data", i),  out_data2,  tbl[i].exp_data);
    end

    // ---------------- K=3 explicit with out-of-range select ----------------
    do_reset();
    mode = 1'b1;
    step();                                   // idle in EMPTY latches explicit mode
    in_valid = 1'b1; in_sel = 2'd0; in_data = A;
    step();
    chk("k3_first_mask", out_mask3, 3'b001);
    in_sel = 2'd3; in_data = B;
    step();
    chk("k3_err_pulse",  sel_err3,  1'b1);
    chk("k3_err_mask",   out_mask3, 3'b001);
    chk("k3_err_data",   out_data3, {Z, Z, A});
    chk("k3_err_valid",  out_valid3, 1'b0);
    in_valid = 1'b0;
    step();
    chk("k3_err_clear",  sel_err3,  1'b0);
    in_valid = 1'b1; in_sel = 2'd2; in_data = C;
    step();
    in_sel = 2'd1; in_data = D;
    step();
    chk("k3_full_valid", out_valid3, 1'b1);
    chk("k3_full_mask",  out_mask3,  3'b111);
    chk("k3_full_data",  out_data3,  {C, D, A});
    in_valid = 1'b0;
    step();
    chk("k3_drain_valid", out_valid3, 1'b0);
    chk("k3_drain_mask",  out_mask3,  3'b000);

    // ---------------- K=4 flush ----------------
    do_reset();
    in_valid = 1'b1; in_data = A;
    step();
    in_data = B;
    step();
    in_valid = 1'b0; flush = 1'b1; out_ready = 1'b0;
    step();
    chk("k4_flush_valid", out_valid4, 1'b1);
    chk("k4_flush_mask",  out_mask4,  4'b0011);
    chk("k4_flush_data",  out_data4,  {Z, Z, B, A});
    flush = 1'b0;
    step();
    chk("k4_hold_valid",  out_valid4, 1'b1);
    chk("k4_hold_ready",  in_ready4,  1'b0);
    out_ready = 1'b1;
    step();
    chk("k4_drain_valid", out_valid4, 1'b0);
    chk("k4_drain_data",  out_data4,  512'h0);
    flush = 1'b1;
    step();
    chk("k4_empty_flush_valid", out_valid4, 1'b0);
    flush = 1'b0;
    step();
    chk("k4_empty_flush_valid2", out_valid4, 1'b0);
    chk("k4_empty_flush_mask",   out_mask4,  4'b0000);
    in_valid = 1'b1; in_data = C;
    step();
    in_data = D; flush = 1'b1;
    step();
    chk("k4_flush_beat_valid", out_valid4, 1'b1);
    chk("k4_flush_beat_mask",  out_mask4,  4'b0011);
    chk("k4_flush_beat_data",  out_data4,  {Z, Z, D, C});
    in_valid = 1'b0; flush = 1'b0;
    step();

    // ---------------- K=2 asynchronous reset mid-fill ----------------
    do_reset();
    in_valid = 1'b1; in_data = A;
    step();
    chk("rstmid_pre_mask", out_mask2, 2'b01);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_mask",     out_mask2,  2'b00);
    chk("rstmid_data",     out_data2,  256'h0);
    chk("rstmid_valid",    out_valid2, 1'b0);
    chk("rstmid_in_ready", in_ready2,  1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = C;
    step();
    in_data = D;
    step();
    chk("rstmid_new_valid", out_valid2, 1'b1);
    chk("rstmid_new_mask",  out_mask2,  2'b11);
    chk("rstmid_new_data",  out_data2,  {D, C});
    in_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/n_to_kn_demux_buffer.md
# n_to_kn_demux_buffer

Registered, handshaked successor to the combinational N-to-2N demux. Routes input beats of `element_width*(no_of_units/2)` bits into one of `no_of_slots` slots of a packed output vector, either in sequential auto-increment order or by explicit slot select. Presents the assembled vector downstream with valid/ready. Sits between the half-width vector producers and the full-width processing-unit array.

## Interface
Parameters:
- `no_of_units`, 8: processing units; an input beat carries `no_of_units/2` elements.
- `element_width`, 32: bits per element.
- `no_of_slots`, 2: input beats per output vector (K ≥ 2; need not be a power of two).
- Derived: `IN_W = element_width*(no_of_units/2)`, `OUT_W = no_of_slots*IN_W`, `SEL_W = max(1, $clog2(no_of_slots))`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `mode`  in  1  0 = sequential fill, 1 = explicit select; latched only while in EMPTY.
- `in_data`  in  IN_W  input beat.
- `in_sel`  in  SEL_W  target slot; used in explicit mode only.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
- `flush`  in  1  single-cycle request to emit a partially filled vector.
- `out_data`  out  OUT_W  slot s occupies bits `[(s+1)*IN_W-1 : s*IN_W]`.
- `out_mask`  out  K  bit s set = slot s written in this vector.
- `out_valid`  out  1  vector available.
- `out_ready`  in  1  vector consumed when `out_valid && out_ready`.
- `sel_err`  out  1  one-cycle pulse: explicit-mode beat had `in_sel >= K`.

## Operation
- States:
  - EMPTY: mask == 0.
  - FILLING: mask ≠ 0, not yet complete.
  - FULL: `out_valid = 1`.
- Mode latch: `mode_q <= mode` on any cycle in EMPTY with no accept. Mode changes in FILLING or FULL are ignored.
- Sequential mode:
  - Accepted beat is written to slot `wr_ptr` and its mask bit is set.
  - `wr_ptr` increments; the beat written at `wr_ptr == K-1` moves the block to FULL.
- Explicit mode:
  - Accepted beat is written to slot `in_sel` and its mask bit is set. Rewriting an already-set slot overwrites the data; the mask is unchanged.
  - FULL is entered when the mask becomes all ones.
  - `in_sel >= K`: the beat is accepted and dropped, `sel_err` pulses, and state is unchanged.
- Flush:
  - In FILLING: go to FULL with the current mask.
  - In EMPTY: ignored.
  - In FULL: no effect.
  - If a beat is accepted in the same cycle as the flush, it is included in the emitted vector.
- `in_ready = !out_valid || out_ready`. The combinational path from `out_ready` is intended.
- Drain (`out_valid && out_ready`):
  - Data and mask clear to zero, `wr_ptr` returns to 0, and the block returns to EMPTY. Unwritten slots therefore read zero on the next vector.
  - If a beat is accepted in the same cycle, it lands in the fresh vector: slot 0 in sequential mode, `in_sel` in explicit mode. The mask then holds only that bit, and the state is FILLING (or FULL if K-fill rules say so).
- Output holds stable while `out_valid && !out_ready`.

## Timing
- Reset values:
  - `out_data` = 0, `out_mask` = 0, `out_valid` = 0, `sel_err` = 0.
  - `wr_ptr` = 0, `mode_q` = 0, state EMPTY.
  - Hence `in_ready` = 1 during and after reset.
- Latency: the beat completing a vector, or the flush, in cycle N gives `out_valid` = 1 in cycle N+1.
- Throughput: one beat per cycle sustained when `out_ready` is held high. No bubble at vector boundaries.
- Reset asserted mid-fill or in FULL: contents discarded immediately (asynchronous); no partial vector is emitted.
- `sel_err` is registered, asserting in the cycle after the offending accept.

## Structure
- Shared package `demux_pkg`:
  - width helper functions for IN_W, OUT_W and SEL_W;
  - state enum {EMPTY, FILLING, FULL}.
- One sub-module: `slot_onehot_decoder`, which turns a SEL_W index plus an enable into a K-bit one-hot write strobe with an out-of-range flag. It is shared by both modes, since `wr_ptr` feeds it in sequential mode.

## Test plan
- **Sequential fill** (defaults, K=2, IN_W=128, `out_ready` = 1): beats `0xA…A` then `0xB…B` → `out_valid` at cycle 3, `out_data = {B,A}`, `out_mask = 2'b11`. The next beat is accepted in the drain cycle.
- **Explicit out-of-order fill**: `in_sel` = 1 then 0 → vector `{slot1, slot0}` correct. A third beat to `in_sel = 1` before full overwrites slot 1 with mask unchanged. K=3 with `in_sel = 3` → `sel_err` pulse, no state change.
- **Flush partial**: K=4, two sequential beats then `flush` → `out_mask = 4'b0011`, upper slots zero. `flush` in EMPTY → no `out_valid`.
- **Backpressure**: `out_ready` = 0 for 5 cycles with FULL → `in_ready` = 0 and `out_data` stable. Raising `out_ready` while `in_valid` is high → drain plus accept into slot 0 in the same cycle.
- **Reset mid-fill**: `rst_n` low after one of two beats → all outputs zero. After release, a fresh two-beat sequence produces a vector without the stale beat.
- **Mode change**: `mode` toggled during FILLING is ignored until the drain; afterwards the new mode takes effect.
